alu_op_issuer: RTL and testbench
================================

Name: alu_op_issuer

Overview:
- Front-end sequencer that drives the datapath's combinational 4-bit-coded ALU.
- Accepts decoded instruction fields plus operands over a valid/ready handshake.
- Translates them into the ALU control code, presents registered operands to the ALU for one cycle, and captures result and zero.
- Resolves branch outcome, then returns a tagged response over a second valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width.
- TAG_W, 4, width of opaque request tag echoed in the response.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- in_opcode  input  7  RV32I opcode field.
- in_funct3  input  3  funct3 field.
- in_funct7b5  input  1  instruction bit 30.
- in_a  input  WIDTH  rs1 value.
- in_b  input  WIDTH  rs2 value or sign-extended immediate.
- in_tag  input  TAG_W  request tag.
- alu_ctrl  output  4  ALU control code.
- alu_a  output  WIDTH  ALU operand A.
- alu_b  output  WIDTH  ALU operand B.
- alu_y  input  WIDTH  ALU result (combinational from alu_ctrl/alu_a/alu_b).
- alu_zero  input  1  ALU zero flag.
- out_valid  output  1  response present.
- out_ready  input  1  consumer accepts response.
- out_result  output  WIDTH  ALU result (0 for branch/illegal).
- out_taken  output  1  branch taken.
- out_is_branch  output  1  request was a branch.
- out_illegal  output  1  unsupported opcode/funct combination.
- out_tag  output  TAG_W  echoed tag.

Behaviour:
- ALU codes (shared package):
  - AND=0000, OR=0001, ADD=0010, SLL=0011, SLT=0100, SLTU=0101, SUB=0110, XOR=0111, SRL=1000, SRA=1010.
- Decode for R-type (0110011) and I-ALU (0010011), by funct3:
  - 000: ADD; SUB only when R-type and funct7b5=1.
  - 001: SLL.
  - 010: SLT.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when funct7b5=1 (both types).
  - 110: OR.
  - 111: AND.
- Decode for load (0000011) and store (0100011): ADD (address generation).
- Decode for branch (1100011), by funct3:
  - 000 BEQ and 001 BNE: SUB.
  - 100 BLT and 101 BGE: SLT.
  - 110 BLTU and 111 BGEU: SLTU.
  - 010 and 011: illegal.
- Any other opcode: illegal.
- Shift codes: alu_b = in_b masked to its low $clog2(WIDTH) bits, upper bits zero. Otherwise alu_b = in_b.
- FSM states IDLE, EXEC, RESP.
  - in_ready = 1 only in IDLE.
  - IDLE to EXEC: on in_valid && in_ready for a legal request. Register alu_ctrl/alu_a/alu_b/tag/is_branch/funct3.
  - IDLE to RESP: on accept of an illegal request. Set out_illegal=1, out_result=0, out_taken=0. Do not touch the ALU registers.
  - EXEC (exactly 1 cycle) to RESP: capture at end of EXEC.
    - Non-branch: out_result = alu_y, out_taken = 0.
    - Branch: out_result = 0; out_taken = alu_zero for BEQ, !alu_zero for BNE, alu_y[0] for BLT/BLTU, !alu_y[0] for BGE/BGEU.
  - RESP: out_valid = 1. All out_* held stable until out_ready. On out_valid && out_ready go to IDLE.
- Latency and throughput:
  - Legal request accepted at cycle T: out_valid at T+2.
  - Illegal request accepted at cycle T: out_valid at T+1.
  - Next accept no earlier than the cycle after the response handshake.
- ALU outputs: alu_ctrl/alu_a/alu_b hold their last value outside EXEC.
- in_valid while not ready: ignored. Requester holds fields stable until accepted.
- out_ready asserted outside RESP: no effect.
- Reset (rst_n=0 at a clock edge, including mid-EXEC or mid-RESP):
  - State IDLE.
  - out_valid, out_taken, out_is_branch, out_illegal = 0.
  - out_result, out_tag, alu_a, alu_b = 0; alu_ctrl = 0000.
  - Any in-flight request is dropped, no response.
  - in_ready = 1 the first cycle after reset deasserts.

Decomposition:
- Package alu_pkg: ALU code localparams, RV32I opcode localparams, branch funct3 constants.
- One natural sub-module: alu_op_decode, combinational.
  - Inputs: opcode/funct3/funct7b5.
  - Outputs: alu_ctrl, is_branch, is_shift, illegal.
- FSM, operand/result registers and branch resolution live in alu_op_issuer.

Test Plan:
- R-type SUB (funct3=000, funct7b5=1), a=10, b=3, tag=5 -> alu_ctrl=0110 in EXEC; out_valid at T+2, out_result=7, out_tag=5, out_illegal=0.
- I-type SRAI (funct3=101, funct7b5=1), a=0x80000000, b=0x00000424 -> alu_b=0x00000004, alu_ctrl=1010, out_result=0xF8000000.
- BNE a=4, b=4, then BLTU a=1, b=0xFFFFFFFF -> first out_taken=0, out_is_branch=1; second alu_ctrl=0101, out_taken=1.
- Illegal opcode 1111111, tag=9 -> no EXEC, out_valid at T+1, out_illegal=1, out_result=0, out_tag=9.
- Backpressure: ADD 2+2 with out_ready low 5 cycles -> out_valid and out_result=4 held stable, in_ready=0 throughout; IDLE the cycle after the handshake.
- Reset asserted during EXEC of ADD -> next cycle out_valid=0, alu_ctrl=0000, in_ready=1, no response ever emitted for that tag.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control codes, RV32I opcodes and branch funct3 values for the
// ALU issue front-end.
package alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SLL  = 4'b0011;
   localparam logic [3:0] ALU_SLT  = 4'b0100;
   localparam logic [3:0] ALU_SLTU = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_XOR  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1010;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } issue_state_t;

   // Resolve a branch from the ALU result: funct3[2] selects the compare
   // source (zero flag vs. SLT/SLTU bit), funct3[0] inverts the sense.
   function automatic logic branch_taken(input logic [2:0] funct3,
                                         input logic       zero,
                                         input logic       lt_bit);
      logic base;
      base = funct3[2] ? lt_bit : zero;
      return base ^ funct3[0];
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational translation of RV32I opcode/funct fields into an ALU
// control code plus branch/shift/illegal qualifiers.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output logic [3:0] alu_ctrl,
   output logic       is_branch,
   output logic       is_shift,
   output logic       illegal
);

   always_comb begin
      alu_ctrl  = ALU_ADD;
      is_branch = 1'b0;
      is_shift  = 1'b0;
      illegal   = 1'b0;
      case (opcode)
         OP_R, OP_I: begin
            case (funct3)
               3'b000: alu_ctrl = ((opcode == OP_R) && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b001: begin
                  alu_ctrl = ALU_SLL;
                  is_shift = 1'b1;
               end
               3'b010: alu_ctrl = ALU_SLT;
               3'b011: alu_ctrl = ALU_SLTU;
               3'b100: alu_ctrl = ALU_XOR;
               3'b101: begin
                  alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
                  is_shift = 1'b1;
               end
               3'b110: alu_ctrl = ALU_OR;
               default: alu_ctrl = ALU_AND;
            endcase
         end
         OP_LOAD, OP_STORE: alu_ctrl = ALU_ADD;
         OP_BRANCH: begin
            is_branch = 1'b1;
            case (funct3)
               F3_BEQ, F3_BNE:   alu_ctrl = ALU_SUB;
               F3_BLT, F3_BGE:   alu_ctrl = ALU_SLT;
               F3_BLTU, F3_BGEU: alu_ctrl = ALU_SLTU;
               default:          illegal  = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_op_issuer.sv
// Sequencer that issues one decoded request to the external combinational
// ALU, captures its result, resolves branches and returns a tagged response.
//
// state | meaning
// IDLE  | ready for a request; accept legal -> EXEC, illegal -> RESP
// EXEC  | registered operands drive the ALU for one cycle; capture at end
// RESP  | response valid and held stable until out_ready
module alu_op_issuer
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       in_opcode,
   input  logic [2:0]       in_funct3,
   input  logic             in_funct7b5,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic [3:0]       alu_ctrl,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_y,
   input  logic             alu_zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_taken,
   output logic             out_is_branch,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] SHIFT_MASK = {{(WIDTH-SHW){1'b0}}, {SHW{1'b1}}};

   issue_state_t     r_state;
   issue_state_t     w_next;
   logic             w_accept;

   logic [3:0]       w_dec_ctrl;
   logic             w_dec_branch;
   logic             w_dec_shift;
   logic             w_dec_illegal;
   logic [WIDTH-1:0] w_b_issue;
   logic             w_taken;

   logic [3:0]       r_alu_ctrl;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [2:0]       r_funct3;
   logic             r_is_branch;
   logic [TAG_W-1:0] r_tag;
   logic [WIDTH-1:0] r_result;
   logic             r_taken;
   logic             r_illegal;

   alu_op_decode u_decode (
      .opcode    (in_opcode),
      .funct3    (in_funct3),
      .funct7b5  (in_funct7b5),
      .alu_ctrl  (w_dec_ctrl),
      .is_branch (w_dec_branch),
      .is_shift  (w_dec_shift),
      .illegal   (w_dec_illegal)
   );

   assign w_b_issue = w_dec_shift ? (in_b & SHIFT_MASK) : in_b;
   assign w_taken   = branch_taken(r_funct3, alu_zero, alu_y[0]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      w_accept  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            w_accept = in_valid;
            if (in_valid) begin
               w_next = w_dec_illegal ? ST_RESP : ST_EXEC;
            end
         end
         ST_EXEC: begin
            w_next = ST_RESP;
         end
         ST_RESP: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_next = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_alu_ctrl  <= ALU_AND;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_funct3    <= '0;
         r_is_branch <= 1'b0;
         r_tag       <= '0;
         r_result    <= '0;
         r_taken     <= 1'b0;
         r_illegal   <= 1'b0;
      end else if (w_accept) begin
         r_tag <= in_tag;
         if (w_dec_illegal) begin
            // ALU operand registers deliberately keep their previous value
            r_illegal   <= 1'b1;
            r_result    <= '0;
            r_taken     <= 1'b0;
            r_is_branch <= 1'b0;
         end else begin
            r_alu_ctrl  <= w_dec_ctrl;
            r_alu_a     <= in_a;
            r_alu_b     <= w_b_issue;
            r_funct3    <= in_funct3;
            r_is_branch <= w_dec_branch;
            r_illegal   <= 1'b0;
         end
      end else if (r_state == ST_EXEC) begin
         r_result <= r_is_branch ? '0 : alu_y;
         r_taken  <= r_is_branch & w_taken;
      end
   end

   assign alu_ctrl      = r_alu_ctrl;
   assign alu_a         = r_alu_a;
   assign alu_b         = r_alu_b;
   assign out_result    = r_result;
   assign out_taken     = r_taken;
   assign out_is_branch = r_is_branch;
   assign out_illegal   = r_illegal;
   assign out_tag       = r_tag;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer with a behavioural ALU on the datapath side.
module tb_alu_op_issuer;

   localparam int WIDTH = 32;
   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [6:0]       in_opcode;
   logic [2:0]       in_funct3;
   logic             in_funct7b5;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [TAG_W-1:0] in_tag;
   logic [3:0]       alu_ctrl;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_y;
   logic             alu_zero;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_taken;
   logic             out_is_branch;
   logic             out_illegal;
   logic [TAG_W-1:0] out_tag;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_op_issuer #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_opcode     (in_opcode),
      .in_funct3     (in_funct3),
      .in_funct7b5   (in_funct7b5),
      .in_a          (in_a),
      .in_b          (in_b),
      .in_tag        (in_tag),
      .alu_ctrl      (alu_ctrl),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_y         (alu_y),
      .alu_zero      (alu_zero),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_taken     (out_taken),
      .out_is_branch (out_is_branch),
      .out_illegal   (out_illegal),
      .out_tag       (out_tag)
   );

   // Behavioural stand-in for the datapath ALU
   always_comb begin
      alu_y = '0;
      case (alu_ctrl)
         4'b0000: alu_y = alu_a & alu_b;
         4'b0001: alu_y = alu_a | alu_b;
         4'b0010: alu_y = alu_a + alu_b;
         4'b0011: alu_y = alu_a << alu_b[4:0];
         4'b0100: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
         4'b0101: alu_y = {31'd0, alu_a < alu_b};
         4'b0110: alu_y = alu_a - alu_b;
         4'b0111: alu_y = alu_a ^ alu_b;
         4'b1000: alu_y = alu_a >> alu_b[4:0];
         4'b1010: alu_y = $unsigned($signed(alu_a) >>> alu_b[4:0]);
         default: alu_y = '0;
      endcase
      alu_zero = (alu_y == '0);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one edge; it is accepted because callers only
   // issue from IDLE. Returns one step after the accepting edge.
   task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
      in_opcode   = opc;
      in_funct3   = f3;
      in_funct7b5 = f7;
      in_a        = a;
      in_b        = b;
      in_tag      = tag;
      in_valid    = 1'b1;
      chk("ready_before_accept", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("idle_after_hs_ready", {31'd0, in_ready}, 32'd1);
      chk("idle_after_hs_valid", {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      in_opcode   = '0;
      in_funct3   = '0;
      in_funct7b5 = 1'b0;
      in_a        = '0;
      in_b        = '0;
      in_tag      = '0;
      tick();
      tick();
      rst_n = 1'b1;

      chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_alu_ctrl",  {28'd0, alu_ctrl}, 32'h0);
      chk("rst_out_tag",   {28'd0, out_tag}, 32'h0);

      // R-type SUB 10-3, tag 5
      send(7'b0110011, 3'b000, 1'b1, 32'd10, 32'd3, 4'd5);
      chk("sub_exec_ctrl",  {28'd0, alu_ctrl}, 32'h6);
      chk("sub_exec_valid", {31'd0, out_valid}, 32'd0);
      chk("sub_exec_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("sub_valid",   {31'd0, out_valid}, 32'd1);
      chk("sub_result",  out_result, 32'd7);
      chk("sub_tag",     {28'd0, out_tag}, 32'd5);
      chk("sub_illegal", {31'd0, out_illegal}, 32'd0);
      chk("sub_branch",  {31'd0, out_is_branch}, 32'd0);
      handshake();

      // SRAI 0x80000000 >>> (0x424 & 31)
      send(7'b0010011, 3'b101, 1'b1, 32'h8000_0000, 32'h0000_0424, 4'd1);
      chk("srai_ctrl",  {28'd0, alu_ctrl}, 32'hA);
      chk("srai_alu_b", alu_b, 32'h0000_0004);
      chk("srai_alu_a", alu_a, 32'h8000_0000);
      tick();
      chk("srai_result", out_result, 32'hF800_0000);
      handshake();

      // BNE equal operands -> not taken
      send(7'b1100011, 3'b001, 1'b0, 32'd4, 32'd4, 4'd2);
      chk("bne_ctrl", {28'd0, alu_ctrl}, 32'h6);
      tick();
      chk("bne_valid",  {31'd0, out_valid}, 32'd1);
      chk("bne_taken",  {31'd0, out_taken}, 32'd0);
      chk("bne_branch", {31'd0, out_is_branch}, 32'd1);
      chk("bne_result", out_result, 32'd0);
      handshake();

      // BLTU 1 < 0xFFFFFFFF -> taken
      send(7'b1100011, 3'b110, 1'b0, 32'd1, 32'hFFFF_FFFF, 4'd3);
      chk("bltu_ctrl", {28'd0, alu_ctrl}, 32'h5);
      chk("bltu_alu_b", alu_b, 32'hFFFF_FFFF);
      tick();
      chk("bltu_taken",  {31'd0, out_taken}, 32'd1);
      chk("bltu_result", out_result, 32'd0);
      handshake();

      // BGE -5 >= 3 -> not taken (signed compare)
      send(7'b1100011, 3'b101, 1'b0, 32'hFFFF_FFFB, 32'd3, 4'd4);
      chk("bge_ctrl", {28'd0, alu_ctrl}, 32'h4);
      tick();
      chk("bge_taken", {31'd0, out_taken}, 32'd0);
      handshake();

      // Illegal opcode: response one cycle after accept, ALU regs untouched
      send(7'b1111111, 3'b000, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 4'd9);
      chk("ill_valid",   {31'd0, out_valid}, 32'd1);
      chk("ill_illegal", {31'd0, out_illegal}, 32'd1);
      chk("ill_result",  out_result, 32'd0);
      chk("ill_tag",     {28'd0, out_tag}, 32'd9);
      chk("ill_taken",   {31'd0, out_taken}, 32'd0);
      chk("ill_alu_a_kept", alu_a, 32'hFFFF_FFFB);
      chk("ill_alu_ctrl_kept", {28'd0, alu_ctrl}, 32'h4);
      handshake();

      // Illegal branch funct3 010
      send(7'b1100011, 3'b010, 1'b0, 32'd0, 32'd0, 4'd6);
      chk("illbr_valid",   {31'd0, out_valid}, 32'd1);
      chk("illbr_illegal", {31'd0, out_illegal}, 32'd1);
      handshake();

      // Load address ADD, also checks out_illegal cleared after an illegal
      send(7'b0000011, 3'b010, 1'b0, 32'h0000_1000, 32'hFFFF_FFFC, 4'd7);
      chk("ld_ctrl", {28'd0, alu_ctrl}, 32'h2);
      tick();
      chk("ld_result",  out_result, 32'h0000_0FFC);
      chk("ld_illegal", {31'd0, out_illegal}, 32'd0);
      handshake();

      // Backpressure: ADD 2+2 held for 5 cycles; a new request is ignored
      send(7'b0110011, 3'b000, 1'b0, 32'd2, 32'd2, 4'd8);
      tick();
      in_opcode = 7'b0110011;
      in_funct3 = 3'b100;
      in_a      = 32'hFFFF_0000;
      in_b      = 32'h0000_FFFF;
      in_tag    = 4'd15;
      in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid",  {31'd0, out_valid}, 32'd1);
         chk("bp_result", out_result, 32'd4);
         chk("bp_tag",    {28'd0, out_tag}, 32'd8);
         chk("bp_ready",  {31'd0, in_ready}, 32'd0);
         tick();
      end
      in_valid = 1'b0;
      handshake();

      // Reset during EXEC: request dropped, no response ever
      send(7'b0110011, 3'b000, 1'b0, 32'd5, 32'd6, 4'd12);
      chk("rx_exec_ctrl", {28'd0, alu_ctrl}, 32'h2);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rx_valid",  {31'd0, out_valid}, 32'd0);
      chk("rx_ctrl",   {28'd0, alu_ctrl}, 32'h0);
      chk("rx_alu_a",  alu_a, 32'd0);
      chk("rx_alu_b",  alu_b, 32'd0);
      chk("rx_result", out_result, 32'd0);
      chk("rx_tag",    {28'd0, out_tag}, 32'd0);
      chk("rx_ready",  {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rx_no_resp", {31'd0, out_valid}, 32'd0);
      end
      out_ready = 1'b0;

      // XOR after reset still works
      send(7'b0110011, 3'b100, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'd11);
      tick();
      chk("xor_result", out_result, 32'hF00F_F00F);
      chk("xor_tag",    {28'd0, out_tag}, 32'd11);
      handshake();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
